usb_bit_stuff_nrzi: RTL and testbench
=====================================

USB_BIT_STUFF_NRZI -- requirements
Module: usb_bit_stuff_nrzi

Interface
REQ-001 SHALL have parameter STUFF_LEN, default 6, consecutive 1s before a stuffed 0 is inserted.
REQ-002 SHALL have port clk  input  1  bit-rate clock; all logic on posedge.
REQ-003 SHALL have port rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a packet; sampled only in IDLE.
REQ-005 SHALL have port bit_in  input  1  next packet bit from upstream FIFO/bsMux; SYNC and PID already included.
REQ-006 SHALL have port bit_valid  input  1  bit_in is valid; FIFO not empty.
REQ-007 SHALL have port bit_last  input  1  bit_in is the final packet bit.
REQ-008 SHALL have port bit_rd  output  1  combinational consume strobe; drives FIFO re.
REQ-009 SHALL have ports dp, dm  output  1 each  registered line state: J=10, K=01, SE0=00.
REQ-010 SHALL have port out_en  output  1  registered transceiver drive enable.
REQ-011 SHALL have port busy  output  1  state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when EOP completes.
REQ-013 SHALL have port err  output  1  one-cycle pulse on upstream underrun.
REQ-014 SHALL have port stuff_cnt  output  8  stuffed bits in the current packet.

Function
REQ-015 SHALL use states IDLE, SEND, STUFF, EOP1, EOP2, EOPJ.
REQ-016 IDLE: SHALL hold dp/dm=J and out_en=0; start=1 SHALL set out_en=1 and go to SEND at the next edge, with the line held at J.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 SEND: bit_rd SHALL equal bit_valid.
REQ-019 Each consumed bit SHALL appear on dp/dm at the next edge: a 0 toggles J<->K, a 1 holds the line.
REQ-020 The ones counter SHALL increment on each consumed 1, clear on each consumed 0, and clear on entry to SEND from IDLE.
REQ-021 When a consumed 1 brings the counter to STUFF_LEN, the next state SHALL be STUFF.
REQ-022 STUFF: bit_rd SHALL be 0; the line SHALL toggle (stuffed 0); the counter SHALL clear; stuff_cnt SHALL increment, saturating at 255; return to SEND, or to EOP1 if the preceding bit was bit_last.
REQ-023 A consumed bit with bit_last=1 and no stuff pending SHALL go to EOP1.
REQ-024 EOP1 and EOP2 SHALL each drive SE0 for one cycle; EOPJ SHALL drive J for one cycle; then state SHALL go to IDLE with out_en=0 and done=1 in that same cycle.
REQ-025 In SEND with bit_valid=0 (underrun), the block SHALL pulse err, hold the line for that cycle, and go to EOP1 (abort).
REQ-026 bit_last SHALL be ignored when bit_rd=0.
REQ-027 stuff_cnt SHALL clear on IDLE->SEND and hold its value after done.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, dp=1, dm=0, out_en=0, done=0, err=0, counters=0, from any state including mid-packet.
REQ-029 bit_rd SHALL be 0 while rst is high.

Configuration
REQ-030 Macro USB_STUFF_CNT_EN defined: stuff_cnt counter SHALL be implemented per REQ-022/REQ-027.
REQ-031 Macro USB_STUFF_CNT_EN undefined: stuff_cnt SHALL be tied to 0, the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package usb_pkg SHALL hold: the state enum; line-state constants J, K, SE0 as 2-bit {dp,dm}; the default STUFF_LEN.
REQ-033 NRZI line encoding SHALL be a sub-module nrzi_enc (inputs: toggle, hold, force_se0, force_j; output: registered {dp,dm}).

Verification
REQ-034 Reset then start with bits 0,1,0,0 (last on 4th) -> dp/dm K,K,J,K, then SE0,SE0,J, then out_en=0 and done=1.
REQ-035 Eight 1s after a 0 -> after the 6th 1: one cycle with bit_rd=0 and a line toggle; stuff_cnt=1; total 10 line bit-times before EOP.
REQ-036 Six 1s with the 6th flagged bit_last -> stuffed toggle emitted, then SE0,SE0,J.
REQ-037 bit_valid dropped mid-packet after 3 bits -> err pulse, SE0,SE0,J, done, back to IDLE.
REQ-038 rst asserted in STUFF -> same-cycle (async) dp/dm=J, out_en=0, busy=0; next start runs a full packet correctly.
REQ-039 Build without USB_STUFF_CNT_EN, rerun REQ-035 -> stuff_cnt=0 and line output identical to REQ-035.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB bit-stuffing NRZI transmitter: FSM states,
// line-state encodings and the default stuffing run length.
package usb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    STUFF = 3'd2,
    EOP1  = 3'd3,
    EOP2  = 3'd4,
    EOPJ  = 3'd5
  } usb_state_e;

  // Line states as {dp, dm}
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  localparam int STUFF_LEN_DEF = 6;

endpackage

// File: rtl/usb_bit_stuff_nrzi_if.sv
// Upstream bit stream handshake between the packet FIFO (master) and the
// bit-stuffing transmitter (slave).
interface usb_bit_stuff_nrzi_if;

  logic bit_in;
  logic bit_valid;
  logic bit_last;
  logic bit_rd;

  modport master (output bit_in, output bit_valid, output bit_last, input bit_rd);
  modport slave  (input bit_in, input bit_valid, input bit_last, output bit_rd);

endinterface

// File: rtl/nrzi_enc.sv
// NRZI line encoder: registered {dp,dm} that toggles J<->K, holds, or is
// forced to SE0 / J. SE0 has priority over J, which has priority over toggle.
module nrzi_enc
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       toggle,
  input  logic       hold,
  input  logic       force_se0,
  input  logic       force_j,
  output logic [1:0] line
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            line <= J;
    else if (force_se0) line <= SE0;
    else if (force_j)   line <= J;
    else if (toggle)    line <= (line == J) ? K : J;
    else if (hold)      line <= line;
  end

endmodule

// File: rtl/usb_bit_stuff_nrzi.sv
// USB transmit bit stuffer + NRZI encoder with EOP generation.
// Optional stuffed-bit counter enabled by defining USB_STUFF_CNT_EN.
module usb_bit_stuff_nrzi
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  usb_bit_stuff_nrzi_if.slave  up,
  output logic                 dp,
  output logic                 dm,
  output logic                 out_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           stuff_cnt
);

  localparam logic [7:0] STUFF_LAST = 8'(STUFF_LEN - 1);

  usb_state_e state, next_state;
  logic [7:0] ones_cnt;
  logic       last_q;
  logic       rd;
  logic       toggle, hold, force_se0, force_j;
  logic [1:0] line;

  always_comb begin
    next_state = state;
    rd         = 1'b0;
    err        = 1'b0;
    toggle     = 1'b0;
    hold       = 1'b0;
    force_se0  = 1'b0;
    force_j    = 1'b0;
    case (state)
      IDLE: begin
        force_j = 1'b1;
        if (start) next_state = SEND;
      end
      SEND: begin
        if (up.bit_valid) begin
          rd = 1'b1;
          if (up.bit_in) begin
            hold = 1'b1;
            // A run reaching STUFF_LEN takes precedence; STUFF then sees last_q
            if (ones_cnt == STUFF_LAST) next_state = STUFF;
            else if (up.bit_last)       next_state = EOP1;
          end else begin
            toggle = 1'b1;
            if (up.bit_last) next_state = EOP1;
          end
        end else begin
          err        = 1'b1;
          hold       = 1'b1;
          next_state = EOP1;
        end
      end
      STUFF: begin
        toggle     = 1'b1;
        next_state = last_q ? EOP1 : SEND;
      end
      EOP1: begin
        force_se0  = 1'b1;
        next_state = EOP2;
      end
      EOP2: begin
        force_se0  = 1'b1;
        next_state = EOPJ;
      end
      EOPJ: begin
        force_j    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ones_cnt <= 8'd0;
      last_q   <= 1'b0;
      out_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state  <= next_state;
      out_en <= (next_state != IDLE);
      done   <= (state == EOPJ);
      if (state == IDLE && start) begin
        ones_cnt <= 8'd0;
        last_q   <= 1'b0;
      end else if (rd) begin
        ones_cnt <= up.bit_in ? ones_cnt + 8'd1 : 8'd0;
        last_q   <= up.bit_last;
      end else if (state == STUFF) begin
        ones_cnt <= 8'd0;
      end
    end
  end

`ifdef USB_STUFF_CNT_EN
  // Saturating count of stuffed bits; survives done until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         stuff_cnt <= 8'd0;
    else if (state == IDLE && start) stuff_cnt <= 8'd0;
    else if (state == STUFF && stuff_cnt != 8'hFF)
      stuff_cnt <= stuff_cnt + 8'd1;
  end
`else
  assign stuff_cnt = 8'd0;
`endif

  nrzi_enc u_nrzi_enc (
    .clk       (clk),
    .rst       (rst),
    .toggle    (toggle),
    .hold      (hold),
    .force_se0 (force_se0),
    .force_j   (force_j),
    .line      (line)
  );

  assign {dp, dm}  = line;
  assign up.bit_rd = rd;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_usb_bit_stuff_nrzi.sv
// Self-checking bench for usb_bit_stuff_nrzi: directed packets plus random
// packets compared slot-by-slot against a stuffing/NRZI reference model.
module tb_usb_bit_stuff_nrzi;

  localparam int STUFF_LEN = 6;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  typedef enum {SLOT_DATA, SLOT_STUFF, SLOT_ABORT, SLOT_EOP} slot_kind_e;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dp, dm, out_en, busy, done, err;
  logic [7:0] stuff_cnt;

  int checks = 0;
  int errors = 0;

  bit         pkt_bits[$];
  slot_kind_e kinds[$];
  logic [1:0] lines[$];
  int         exp_stuffs;

  usb_bit_stuff_nrzi_if up ();

  usb_bit_stuff_nrzi #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .up        (up),
    .dp        (dp),
    .dm        (dm),
    .out_en    (out_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .stuff_cnt (stuff_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] lv);
    return (lv == LJ) ? LK : LJ;
  endfunction

  function automatic logic [7:0] expStuffCnt();
`ifdef USB_STUFF_CNT_EN
    return (exp_stuffs > 255) ? 8'hFF : 8'(exp_stuffs);
`else
    return 8'd0;
`endif
  endfunction

  // One slot per DUT cycle after the start edge, with the line level expected after it
  task automatic buildModel(input int abort_at);
    logic [1:0] level;
    int ones;
    kinds.delete();
    lines.delete();
    level = LJ;
    ones = 0;
    exp_stuffs = 0;
    for (int i = 0; i < pkt_bits.size(); i++) begin
      if (i == abort_at) begin
        kinds.push_back(SLOT_ABORT);
        lines.push_back(level);
        break;
      end
      kinds.push_back(SLOT_DATA);
      if (!pkt_bits[i]) level = flip(level);
      lines.push_back(level);
      ones = pkt_bits[i] ? ones + 1 : 0;
      if (ones == STUFF_LEN) begin
        ones = 0;
        exp_stuffs++;
        level = flip(level);
        kinds.push_back(SLOT_STUFF);
        lines.push_back(level);
      end
    end
    kinds.push_back(SLOT_EOP); lines.push_back(LSE0);
    kinds.push_back(SLOT_EOP); lines.push_back(LSE0);
    kinds.push_back(SLOT_EOP); lines.push_back(LJ);
  endtask

  task automatic applyStimulus(input int abort_at, input bit rst_on_stuff);
    int idx;
    int n;
    n = pkt_bits.size();
    buildModel(abort_at);
    @(negedge clk);
    start = 1'b1;
    up.bit_valid = 1'b1;
    up.bit_in = 1'($urandom);
    up.bit_last = 1'($urandom);
    #1;
    checkOutput("idle_rd", 32'(up.bit_rd), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("start_line", 32'({dp, dm}), 32'(LJ));
    checkOutput("start_oe", 32'(out_en), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done", 32'(done), 32'd0);
    idx = 0;
    for (int s = 0; s < kinds.size(); s++) begin
      @(negedge clk);
      start = 1'($urandom);
      up.bit_in = (idx < n) ? pkt_bits[idx] : 1'($urandom);
      case (kinds[s])
        SLOT_DATA: begin
          up.bit_valid = 1'b1;
          up.bit_last = (idx == n - 1);
        end
        SLOT_ABORT: begin
          up.bit_valid = 1'b0;
          up.bit_last = 1'($urandom);
        end
        default: begin
          up.bit_valid = 1'($urandom);
          up.bit_last = 1'($urandom);
        end
      endcase
      if (rst_on_stuff && kinds[s] == SLOT_STUFF) begin
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_line", 32'({dp, dm}), 32'(LJ));
        checkOutput("rst_oe", 32'(out_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_rd", 32'(up.bit_rd), 32'd0);
        checkOutput("rst_stuff_cnt", 32'(stuff_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        return;
      end
      #1;
      checkOutput("slot_rd", 32'(up.bit_rd), 32'(kinds[s] == SLOT_DATA));
      checkOutput("slot_err", 32'(err), 32'(kinds[s] == SLOT_ABORT));
      if (kinds[s] == SLOT_DATA) idx++;
      @(posedge clk);
      #1;
      checkOutput("slot_line", 32'({dp, dm}), 32'(lines[s]));
      if (s == kinds.size() - 1) begin
        checkOutput("end_oe", 32'(out_en), 32'd0);
        checkOutput("end_done", 32'(done), 32'd1);
        checkOutput("end_busy", 32'(busy), 32'd0);
      end else begin
        checkOutput("pkt_oe", 32'(out_en), 32'd1);
        checkOutput("pkt_done", 32'(done), 32'd0);
        checkOutput("pkt_busy", 32'(busy), 32'd1);
      end
    end
    checkOutput("stuff_cnt", 32'(stuff_cnt), 32'(expStuffCnt()));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_done", 32'(done), 32'd0);
    checkOutput("after_line", 32'({dp, dm}), 32'(LJ));
    checkOutput("after_oe", 32'(out_en), 32'd0);
    checkOutput("stuff_hold", 32'(stuff_cnt), 32'(expStuffCnt()));
  endtask

  initial begin
    int n;
    int abort_at;
    rst = 1'b1;
    start = 1'b0;
    up.bit_in = 1'b1;
    up.bit_valid = 1'b1;
    up.bit_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset checks");
    checkOutput("reset_line", 32'({dp, dm}), 32'(LJ));
    checkOutput("reset_oe", 32'(out_en), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_rd", 32'(up.bit_rd), 32'd0);
    checkOutput("reset_stuff_cnt", 32'(stuff_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed: 0,1,0,0");
    pkt_bits = '{0, 1, 0, 0};
    applyStimulus(-1, 1'b0);

    $display("[TB] directed: 0 then eight 1s");
    pkt_bits = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    applyStimulus(-1, 1'b0);
    checkOutput("req35_slots", 32'(kinds.size()), 32'd13);

    $display("[TB] directed: six 1s, last on sixth");
    pkt_bits = '{1, 1, 1, 1, 1, 1};
    applyStimulus(-1, 1'b0);

    $display("[TB] directed: underrun after 3 bits");
    pkt_bits = '{1, 0, 1, 0, 0, 1};
    applyStimulus(3, 1'b0);

    $display("[TB] directed: reset in STUFF, then full packet");
    pkt_bits = '{0, 1, 1, 1, 1, 1, 1, 1};
    applyStimulus(-1, 1'b1);
    applyStimulus(-1, 1'b0);

    $display("[TB] random packets");
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 30);
      pkt_bits.delete();
      for (int i = 0; i < n; i++) pkt_bits.push_back($urandom_range(0, 3) != 0);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(abort_at, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
